ufm_page_sched: RTL and testbench

Arbitrating fetch scheduler in front of the UFM page reader and the page buffer. Two requesters issue random byte reads into the 32 KiB UFM address space. The block keeps one page (16 bytes) resident and commands a page fetch on a miss. It counts the 16 sequential bytes into the page buffer, then serves the read from the buffer's random port. Requester 1 is typically the boot/config loader; requester 0 is the UART debug path.

---
 rtl/ufm_page_sched.sv | 173 +++++++++++++++++
 tb/tb_ufm_page_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ufm_page_sched.sv
// ufm_page_sched: two-requester byte reader over one resident UFM page.
// A miss flushes the page buffer and fetches 16 bytes before the read.
module ufm_page_sched #(
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [14:0] addr0,
  input  logic [14:0] addr1,
  output logic [1:0]  ack,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        ufm_cmd_valid,
  output logic [10:0] ufm_cmd_page,
  input  logic        ufm_cmd_ready,
  input  logic        ufm_byte_valid,
  output logic        pb_flush,
  output logic [14:0] pb_addr,
  output logic        pb_read_en,
  input  logic        pb_rand_valid,
  input  logic [7:0]  pb_rand_data
);

  localparam int TW = (TIMEOUT > 4) ? $clog2(TIMEOUT) : 2;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    FILL,
    READ
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [10:0]   tag_page;
  logic          tag_valid;
  logic          rr_ptr;
  logic          grant;
  logic [10:0]   lat_page;
  logic [3:0]    lat_off;
  logic [4:0]    fill_cnt;
  logic [TW-1:0] tmo_cnt;

  logic [1:0]    req_eff;
  logic          gnt_sel;
  logic [14:0]   sel_addr;
  logic          hit;
  logic [TW-1:0] tmo_inc;
  logic          tmo_hit;
  logic          fill_done;
  logic          cmd_go;
  logic          cmd_fire;
  logic [1:0]    ack_sel;

  // Arbitration, hit/timeout decode, next state and command outputs.
  always_comb begin
    // The requester being acked this cycle may still hold req; skip it.
    req_eff   = req & ~ack;
    gnt_sel   = (req_eff == 2'b11) ? rr_ptr : req_eff[1];
    sel_addr  = gnt_sel ? addr1 : addr0;
    hit       = tag_valid && (tag_page == sel_addr[14:4]);
    tmo_inc   = tmo_cnt + TW'(1);
    tmo_hit   = (tmo_inc == TW'(TIMEOUT - 1));
    fill_done = ufm_byte_valid && (fill_cnt == 5'd15);
    // The flush pulse gets its own cycle before the fetch command.
    cmd_go    = (state == CMD) && !pb_flush;
    cmd_fire  = cmd_go && ufm_cmd_ready;
    ack_sel   = {grant, ~grant};

    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (|req_eff) state_nxt = hit ? READ : CMD;
      end
      CMD: begin
        if (cmd_fire)     state_nxt = FILL;
        else if (tmo_hit) state_nxt = IDLE;
      end
      FILL: begin
        if (fill_done)    state_nxt = READ;
        else if (tmo_hit) state_nxt = IDLE;
      end
      READ: begin
        if (pb_rand_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    ufm_cmd_valid = cmd_go;
    ufm_cmd_page  = cmd_go ? lat_page : 11'd0;
    pb_read_en    = (state == READ);
    pb_addr       = pb_read_en ? {11'd0, lat_off} : 15'd0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Tag, grant, counters and registered ack/err/rdata/flush pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack       <= 2'b00;
      err       <= 1'b0;
      rdata     <= 8'd0;
      pb_flush  <= 1'b0;
      tag_page  <= 11'd0;
      tag_valid <= 1'b0;
      rr_ptr    <= 1'b0;
      grant     <= 1'b0;
      lat_page  <= 11'd0;
      lat_off   <= 4'd0;
      fill_cnt  <= 5'd0;
      tmo_cnt   <= '0;
    end else begin
      ack      <= 2'b00;
      err      <= 1'b0;
      pb_flush <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req_eff) begin
            grant    <= gnt_sel;
            rr_ptr   <= ~gnt_sel;
            lat_page <= sel_addr[14:4];
            lat_off  <= sel_addr[3:0];
            if (!hit) begin
              pb_flush  <= 1'b1;
              tag_valid <= 1'b0;
              tmo_cnt   <= '0;
            end
          end
        end
        CMD: begin
          if (cmd_fire) begin
            fill_cnt <= 5'd0;
            tmo_cnt  <= '0;
          end else if (tmo_hit) begin
            ack       <= ack_sel;
            err       <= 1'b1;
            tag_valid <= 1'b0;
          end else begin
            tmo_cnt <= tmo_inc;
          end
        end
        FILL: begin
          if (ufm_byte_valid) fill_cnt <= fill_cnt + 5'd1;
          // A completing fill wins over a coincident timeout.
          if (fill_done) begin
            tag_page  <= lat_page;
            tag_valid <= 1'b1;
          end else if (tmo_hit) begin
            ack       <= ack_sel;
            err       <= 1'b1;
            tag_valid <= 1'b0;
          end else begin
            tmo_cnt <= tmo_inc;
          end
        end
        READ: begin
          if (pb_rand_valid) begin
            rdata <= pb_rand_data;
            ack   <= ack_sel;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ufm_page_sched.sv
// tb_ufm_page_sched: directed vectors plus hand sequences for ufm_page_sched.
// Bench models the UFM reader and page buffer; UFM byte = addr[7:0] ^ 8'hA5.
module tb_ufm_page_sched;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [14:0] addr0 = 15'd0;
  logic [14:0] addr1 = 15'd0;
  logic [1:0]  ack;
  logic        err;
  logic [7:0]  rdata;
  logic        ufm_cmd_valid;
  logic [10:0] ufm_cmd_page;
  logic        ufm_cmd_ready = 1'b1;
  logic        ufm_byte_valid = 1'b0;
  logic        pb_flush;
  logic [14:0] pb_addr;
  logic        pb_read_en;
  logic        pb_rand_valid = 1'b0;
  logic [7:0]  pb_rand_data = 8'd0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  pb_mem [16];
  logic [3:0]  wp = 4'd0;
  logic [10:0] cur_page = 11'd0;
  logic [10:0] last_page = 11'd0;
  logic        rd_wait = 1'b0;
  int bytes_left = 0;
  int byte_limit = 16;
  int byte_cnt = 0;
  int fetch_cnt = 0;
  int flush_cnt = 0;
  int viol_cnt = 0;

  ufm_page_sched #(.TIMEOUT(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .addr0(addr0),
    .addr1(addr1),
    .ack(ack),
    .err(err),
    .rdata(rdata),
    .ufm_cmd_valid(ufm_cmd_valid),
    .ufm_cmd_page(ufm_cmd_page),
    .ufm_cmd_ready(ufm_cmd_ready),
    .ufm_byte_valid(ufm_byte_valid),
    .pb_flush(pb_flush),
    .pb_addr(pb_addr),
    .pb_read_en(pb_read_en),
    .pb_rand_valid(pb_rand_valid),
    .pb_rand_data(pb_rand_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ufm_byte(input logic [14:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // UFM reader: accepts a command, then streams byte_limit bytes.
  initial begin
    forever begin
      @(negedge clk);
      ufm_byte_valid = 1'b0;
      if (pb_flush) wp = 4'd0;
      if (bytes_left > 0) begin
        ufm_byte_valid = 1'b1;
        pb_mem[wp] = ufm_byte({cur_page, wp});
        wp = wp + 4'd1;
        bytes_left--;
        byte_cnt++;
      end
      if (ufm_cmd_valid && ufm_cmd_ready) begin
        fetch_cnt++;
        last_page = ufm_cmd_page;
        cur_page = ufm_cmd_page;
        bytes_left = byte_limit;
      end
    end
  end

  // Page buffer random port: data valid one cycle after read_en.
  initial begin
    forever begin
      @(negedge clk);
      pb_rand_valid = 1'b0;
      if (rd_wait) begin
        pb_rand_valid = 1'b1;
        pb_rand_data = pb_mem[pb_addr[3:0]];
        rd_wait = 1'b0;
      end else if (pb_read_en) begin
        rd_wait = 1'b1;
      end
    end
  end

  // Flush pulses and cmd-vs-ack/read overlap.
  initial begin
    forever begin
      @(negedge clk);
      if (pb_flush) flush_cnt++;
      if (ufm_cmd_valid && (ack != 2'b00 || pb_read_en)) viol_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_ack(input int budget, output logic [1:0] a,
                          output int cyc);
    a = 2'b00;
    cyc = 0;
    while (a == 2'b00 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      a = ack;
    end
    if (a == 2'b00) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_wait: no ack in %0d cycles", budget);
    end
  endtask

  typedef struct {
    logic [1:0]  rq;
    logic [14:0] a0;
    logic [14:0] a1;
    int          blim;
    logic [1:0]  e_ack;
    logic        e_err;
    logic        chk_d;
    logic [7:0]  e_data;
    int          e_cyc;
    int          e_fetch;
    logic [10:0] e_page;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int f0;
    int fl0;
    int cyc;
    logic [1:0] a;
    f0 = fetch_cnt;
    fl0 = flush_cnt;
    byte_limit = v.blim;
    @(negedge clk);
    addr0 = v.a0;
    addr1 = v.a1;
    req = v.rq;
    wait_ack(200, a, cyc);
    req = req & ~a;
    check({tag, " ack"}, a, v.e_ack);
    check({tag, " err"}, err, v.e_err);
    if (v.chk_d) check({tag, " rdata"}, rdata, v.e_data);
    check({tag, " latency"}, cyc, v.e_cyc);
    check({tag, " fetches"}, fetch_cnt - f0, v.e_fetch);
    check({tag, " flushes"}, flush_cnt - fl0, v.e_fetch);
    if (v.e_fetch != 0) check({tag, " page"}, last_page, v.e_page);
  endtask

  vec_t vecs[10];

  initial begin
    logic [1:0] a;
    logic [1:0] ea;
    int cyc;
    int f0;
    int b0;
    int act;
    vec_t rv;

    // Miss latency 21: flush, cmd, 16 bytes, read_en, rand_valid, ack.
    // Hit latency 3. Timeout: ack 63 edges after cmd accept -> 66.
    vecs[0] = '{2'b01, 15'h0013, 15'h0000, 16,
                2'b01, 1'b0, 1'b1, 8'hB6, 21, 1, 11'h001};
    vecs[1] = '{2'b10, 15'h0000, 15'h001F, 16,
                2'b10, 1'b0, 1'b1, 8'hBA, 3, 0, 11'h000};
    vecs[2] = '{2'b01, 15'h0050, 15'h0000, 16,
                2'b01, 1'b0, 1'b1, 8'hF5, 21, 1, 11'h005};
    vecs[3] = '{2'b01, 15'h0067, 15'h0000, 16,
                2'b01, 1'b0, 1'b1, 8'hC2, 21, 1, 11'h006};
    vecs[4] = '{2'b10, 15'h0000, 15'h006A, 16,
                2'b10, 1'b0, 1'b1, 8'hCF, 3, 0, 11'h000};
    vecs[5] = '{2'b01, 15'h005C, 15'h0000, 16,
                2'b01, 1'b0, 1'b1, 8'hF9, 21, 1, 11'h005};
    vecs[6] = '{2'b10, 15'h0000, 15'h7FFF, 16,
                2'b10, 1'b0, 1'b1, 8'h5A, 21, 1, 11'h7FF};
    vecs[7] = '{2'b01, 15'h0123, 15'h0000, 10,
                2'b01, 1'b1, 1'b0, 8'h00, 66, 1, 11'h012};
    vecs[8] = '{2'b01, 15'h0124, 15'h0000, 16,
                2'b01, 1'b0, 1'b1, 8'h81, 21, 1, 11'h012};
    vecs[9] = '{2'b10, 15'h0000, 15'h012F, 16,
                2'b10, 1'b0, 1'b1, 8'h8A, 3, 0, 11'h000};

    repeat (3) @(negedge clk);
    check("rst ack", ack, 2'b00);
    check("rst err", err, 1'b0);
    check("rst rdata", rdata, 8'h00);
    check("rst cmd_valid", ufm_cmd_valid, 1'b0);
    check("rst cmd_page", ufm_cmd_page, 11'h000);
    check("rst flush", pb_flush, 1'b0);
    check("rst read_en", pb_read_en, 1'b0);
    check("rst pb_addr", pb_addr, 15'h0000);
    rst = 1'b0;

    // Contention from reset on page 0, then strict alternation.
    byte_limit = 16;
    f0 = fetch_cnt;
    @(negedge clk);
    addr0 = 15'h0003;
    addr1 = 15'h0009;
    req = 2'b11;
    wait_ack(200, a, cyc);
    check("cont first ack", a, 2'b01);
    check("cont first rdata", rdata, 8'hA6);
    check("cont first latency", cyc, 21);
    for (int i = 0; i < 21; i++) begin
      wait_ack(20, a, cyc);
      ea = (i % 2 == 0) ? 2'b10 : 2'b01;
      check($sformatf("cont %0d ack", i), a, ea);
      check($sformatf("cont %0d latency", i), cyc, 3);
      check($sformatf("cont %0d rdata", i), rdata,
            (ea == 2'b10) ? 8'hAC : 8'hA6);
    end
    req = 2'b00;
    check("cont fetches", fetch_cnt - f0, 1);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end
    repeat (3) @(negedge clk);
    check("rdata hold", rdata, 8'h8A);

    // Reset after 7 fill bytes, stray strobes, then a full refetch.
    byte_limit = 7;
    b0 = byte_cnt;
    @(negedge clk);
    addr0 = 15'h0230;
    req = 2'b01;
    cyc = 0;
    while (byte_cnt - b0 < 7 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("midfill bytes", byte_cnt - b0, 7);
    @(negedge clk);
    rst = 1'b1;
    req = 2'b00;
    @(negedge clk);
    check("midrst ack", ack, 2'b00);
    check("midrst err", err, 1'b0);
    check("midrst rdata", rdata, 8'h00);
    check("midrst cmd_valid", ufm_cmd_valid, 1'b0);
    check("midrst flush", pb_flush, 1'b0);
    check("midrst read_en", pb_read_en, 1'b0);
    check("midrst pb_addr", pb_addr, 15'h0000);
    rst = 1'b0;
    bytes_left = 5;
    act = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack != 2'b00 || ufm_cmd_valid || pb_read_en || pb_flush) act++;
    end
    check("stray activity", act, 0);
    rv = '{2'b01, 15'h0235, 15'h0000, 16,
           2'b01, 1'b0, 1'b1, 8'h90, 21, 1, 11'h023};
    run_vec(rv, "refetch");

    check("cmd overlap", viol_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
